// File: rtl/deserializador_registro.sv
`default_nettype none
// ============================================================================
// Module   : deserializador_registro
// Purpose  : Framed serial-to-parallel front end for the bit-register bank,
//            with an inter-bit timeout that aborts stalled frames.
// Revision : 1.0 - initial release
// ============================================================================
module deserializador_registro #(
    parameter int N       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic [N-1:0] word_out,
    output logic [N-1:0] load_out,
    output logic         word_valid,
    output logic         busy,
    output logic         frame_err
);

    localparam int BCW = $clog2(N + 1);
    localparam int TCW = $clog2(TIMEOUT + 1);

    localparam logic [BCW-1:0] c_BIT_LAST = BCW'(N - 1);
    localparam logic [TCW-1:0] c_TO_LAST  = TCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q;
    logic [N-1:0]   shift_q;
    logic [N-1:0]   word_q;
    logic [N-1:0]   load_q;
    logic [BCW-1:0] bitcnt_q;
    logic [TCW-1:0] tocnt_q;
    logic           word_valid_q;
    logic           busy_q;
    logic           frame_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            word_q       <= '0;
            load_q       <= '1;
            bitcnt_q     <= '0;
            tocnt_q      <= '0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_SHIFT;
                        bitcnt_q <= '0;
                        tocnt_q  <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    // An accepted bit always clears the timeout, even on the expiry cycle.
                    if (bit_valid) begin
                        shift_q  <= {shift_q[N-2:0], bit_in};
                        bitcnt_q <= bitcnt_q + BCW'(1);
                        tocnt_q  <= '0;
                        if (bitcnt_q == c_BIT_LAST) begin
                            state_q      <= S_DONE;
                            word_q       <= {shift_q[N-2:0], bit_in};
                            word_valid_q <= 1'b1;
                            load_q       <= '0;
                        end
                    end else if (tocnt_q == c_TO_LAST) begin
                        state_q     <= S_IDLE;
                        frame_err_q <= 1'b1;
                        shift_q     <= '0;
                        bitcnt_q    <= '0;
                        tocnt_q     <= '0;
                        busy_q      <= 1'b0;
                    end else begin
                        tocnt_q <= tocnt_q + TCW'(1);
                    end
                end
                S_DONE: begin
                    // The bank captures word_out on this edge; hold it from here on.
                    state_q  <= S_IDLE;
                    load_q   <= '1;
                    bitcnt_q <= '0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    load_q  <= '1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign word_out   = word_q;
    assign load_out   = load_q;
    assign word_valid = word_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_deserializador_registro.sv
`default_nettype none
// ============================================================================
// Module   : tb_deserializador_registro
// Purpose  : Directed self-checking bench for deserializador_registro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deserializador_registro;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] word_out;
    logic [7:0] load_out;
    logic       word_valid;
    logic       busy;
    logic       frame_err;

    logic [7:0] bank = 8'h00;
    int         wv_cnt = 0;
    int         fe_cnt = 0;
    int         wv_snap;
    int         passes = 0;
    int         total  = 0;

    deserializador_registro #(.N(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .word_out   (word_out),
        .load_out   (load_out),
        .word_valid (word_valid),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Downstream register bank: a bit holds when load=1, captures D when load=0.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            if (load_out[i] === 1'b0) bank[i] <= word_out[i];
        if (word_valid === 1'b1) wv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    // Sends the top nbits of w, MSB first, with gap idle cycles between bits.
    task automatic send_bits(input logic [7:0] w, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) begin
            send_bit(w[7-i]);
            if (i != nbits - 1)
                for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        tick(); tick();
        chk("rst_word",  word_out,   8'h00);
        chk("rst_load",  load_out,   8'hFF);
        chk("rst_busy",  busy,       1'b0);
        chk("rst_wv",    word_valid, 1'b0);
        chk("rst_fe",    frame_err,  1'b0);
        reset = 1'b0;

        // Back-to-back frame 0xA5
        do_start();
        chk("a5_busy", busy, 1'b1);
        send_bits(8'hA5, 8, 0);
        chk("a5_wv",   word_valid, 1'b1);
        chk("a5_word", word_out,   8'hA5);
        chk("a5_load", load_out,   8'h00);
        chk("a5_busy_done", busy,  1'b1);
        tick();
        chk("a5_wv_end",   word_valid, 1'b0);
        chk("a5_load_end", load_out,   8'hFF);
        chk("a5_idle",     busy,       1'b0);
        chk("a5_bank",     bank,       8'hA5);
        chk("a5_wvcnt",    wv_cnt,     1);

        // Nth bit arrives exactly when the timeout would expire
        do_start();
        send_bits(8'h5A, 7, 0);
        repeat (15) tick();
        chk("edge_busy", busy, 1'b1);
        send_bit(1'b0);
        chk("edge_wv",   word_valid, 1'b1);
        chk("edge_word", word_out,   8'h5A);
        tick();
        chk("edge_fe", fe_cnt, 0);
        chk("edge_bank", bank, 8'h5A);

        // Frame with 3-cycle gaps
        do_start();
        send_bits(8'hA5, 8, 3);
        chk("gap_wv",   word_valid, 1'b1);
        chk("gap_word", word_out,   8'hA5);
        tick();
        chk("gap_fe", fe_cnt, 0);

        // Timeout abort after 3 bits
        wv_snap = wv_cnt;
        do_start();
        send_bits(8'hA5, 3, 0);
        repeat (15) tick();
        chk("to_pre_fe",   frame_err, 1'b0);
        chk("to_pre_busy", busy,      1'b1);
        tick();
        chk("to_fe",   frame_err, 1'b1);
        chk("to_busy", busy,      1'b0);
        chk("to_word", word_out,  8'hA5);
        chk("to_load", load_out,  8'hFF);
        tick();
        chk("to_fe_end", frame_err, 1'b0);
        chk("to_fecnt",  fe_cnt,    1);
        chk("to_wvcnt",  wv_cnt,    wv_snap);

        // Reset mid-frame, then a clean 0x3C frame
        do_start();
        send_bits(8'hC3, 5, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_word", word_out,   8'h00);
        chk("mr_load", load_out,   8'hFF);
        chk("mr_busy", busy,       1'b0);
        chk("mr_wv",   word_valid, 1'b0);
        chk("mr_fe",   frame_err,  1'b0);
        do_start();
        send_bits(8'h3C, 8, 0);
        chk("3c_wv",   word_valid, 1'b1);
        chk("3c_word", word_out,   8'h3C);
        tick();
        chk("3c_bank", bank, 8'h3C);

        // bit_valid in IDLE, start in SHIFT/DONE, bit_valid in DONE are all ignored
        bit_in = 1'b0; bit_valid = 1'b1;
        tick(); tick(); tick();
        bit_valid = 1'b0;
        chk("ig_idle_busy", busy, 1'b0);
        wv_snap = wv_cnt;
        start = 1'b1;
        tick();
        send_bits(8'hFF, 8, 0);
        chk("ig_wv",   word_valid, 1'b1);
        chk("ig_word", word_out,   8'hFF);
        bit_in = 1'b0; bit_valid = 1'b1;
        tick();
        start = 1'b0; bit_valid = 1'b0;
        chk("ig_done_busy", busy,       1'b0);
        chk("ig_done_wv",   word_valid, 1'b0);
        tick();
        chk("ig_busy_after", busy,     1'b0);
        chk("ig_word_after", word_out, 8'hFF);
        chk("ig_bank",       bank,     8'hFF);
        chk("ig_wvcnt",      wv_cnt,   wv_snap + 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/deserializador_registro.md
Name: deserializador_registro

Overview:
- Serial-to-parallel front end placed directly upstream of the team's bit-register bank.
- Collects a framed serial bit stream into an N-bit word.
- Presents the word together with the per-bit hold control the register bank consumes: register holds when its load=1 and captures D when load=0.
- Includes an inter-bit timeout that aborts stalled frames and flags an error.

Parameters:
N, 8, word width in bits (2..32)
TIMEOUT, 16, max cycles allowed between consecutive accepted bits while in SHIFT (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a frame; honoured only in IDLE
bit_in  input  1  serial data bit, sampled when bit_valid=1 in SHIFT
bit_valid  input  1  qualifies bit_in
word_out  output  N  assembled word, MSB received first; drives register-bank D inputs
load_out  output  N  per-bit hold to register bank: all ones = hold, all zeros = capture word_out
word_valid  output  1  one-cycle pulse, word_out is new
busy  output  1  high in SHIFT and DONE
frame_err  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset values, applied on the first rising clk with reset=1:
  - state=IDLE, word_out=0, load_out=all ones, word_valid=0, busy=0, frame_err=0.
  - Shift register, bit counter and timeout counter cleared.
- Reset has priority over every other input, including mid-frame; a partial frame is discarded with no word_valid and no frame_err.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 -> SHIFT next cycle; bit counter=0, timeout counter=0.
  - bit_valid is ignored in IDLE.
- SHIFT:
  - On bit_valid=1: shift_reg <= {shift_reg[N-2:0], bit_in}, bit counter +1, timeout counter cleared.
  - When the Nth bit is accepted -> DONE next cycle.
  - On bit_valid=0: timeout counter +1. Reaching TIMEOUT -> IDLE, frame_err=1 for one cycle, shift register cleared, word_out unchanged.
  - start is ignored in SHIFT and DONE; no restart mid-frame.
- DONE, exactly one cycle:
  - word_out <= shift_reg, word_valid=1, load_out=all zeros.
  - Next cycle -> IDLE with load_out=all ones and word_valid=0.
  - A bit_valid arriving in DONE is dropped.
- Latency: word_valid is asserted 1 cycle after the clock edge that accepts the Nth bit.
- The register bank captures word_out on the edge that ends DONE. word_out is held stable until the next DONE, so the bank and word_out agree from that edge on.
- Output timing: all outputs are registered; no combinational path from any input to any output.
- busy=1 in SHIFT and DONE, 0 in IDLE.
- Counter widths:
  - Bit counter: $clog2(N+1) bits.
  - Timeout counter: $clog2(TIMEOUT+1) bits.
  - Neither counter wraps; both saturate or clear per the rules above.
- Simultaneous events:
  - start with reset: reset wins.
  - Nth bit on the same cycle the timeout counter would expire: the bit is accepted (bit_valid clears the counter first) and there is no error.

Test Plan:
- Reset for 2 cycles -> word_out=0x00, load_out=0xFF, busy=0, word_valid=0, frame_err=0.
- N=8: start, then bits 1,0,1,0,0,1,0,1 on consecutive cycles -> word_valid pulse 1 cycle after the 8th bit, word_out=0xA5, load_out=0x00 for exactly that cycle; the downstream register bank reads 0xA5 afterward.
- Same frame with 3-cycle gaps of bit_valid=0 between bits (TIMEOUT=16) -> word_out=0xA5, no frame_err.
- start, 3 bits, then bit_valid=0 for 16 cycles -> frame_err single pulse, return to IDLE, word_out keeps the previous value 0xA5, no word_valid.
- start, 5 bits of a frame, then reset high 1 cycle -> all outputs at reset values. A new full frame 0x3C then completes with word_out=0x3C.
- start pulsed during SHIFT and bit_valid during IDLE/DONE -> ignored. Frame 0xFF yields exactly one word_valid and word_out=0xFF.
